sfdbs0_err_log_arb: RTL and testbench

// - Shares the single sfdbs0 error-log register set (error_err_log, error_err_data, error_err_idx)

---
 rtl/sfdbs0_err_pkg.sv | 36 +++
 rtl/sfdbs0_rr_arb.sv | 37 +++
 rtl/sfdbs0_err_log_arb.sv | 221 ++++++++++++++++++++++
 tb/tb_sfdbs0_err_log_arb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfdbs0_err_pkg.sv
// Shared types for the sfdbs0 error-log arbiter: reporter record, FSM states, code constants.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: err_rec_t (one reporter's error payload), arb_state_e, ERR_CODE_NONE, popcount8().
package sfdbs0_err_pkg;

   // One error report as it will land in err_log / err_data / err_idx.
   typedef struct packed {
      logic [2:0]  code;
      logic        access;
      logic [5:0]  id;
      logic [31:0] data;
      logic [4:0]  slice_idx;
      logic [3:0]  group_idx;
   } err_rec_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SETTLE  = 2'd2,
      HELD    = 2'd3
   } arb_state_e;

   // A code of zero means "no error" in err_log, so a reporter may never send it.
   localparam logic [2:0] ERR_CODE_NONE = 3'd0;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/sfdbs0_rr_arb.sv
// Round-robin picker: first requester at or above ptr, wrapping past NUM_SRC-1.
// Latency: combinational.
// Backpressure: none; caller decides whether the grant is used.
// Ports: req (per-source request), ptr (search start), gnt (one-hot), idx (binary grant), any (gnt valid).
module sfdbs0_rr_arb #(
   parameter int NUM_SRC = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_SRC-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   always_comb begin
      int c;
      c   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         c = int'(ptr) + k;
         if (c >= NUM_SRC) begin
            c = c - NUM_SRC;
         end
         if (!any && req[c]) begin
            any = 1'b1;
            idx = IDX_W'(c);
         end
      end
      if (any) begin
         gnt[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/sfdbs0_err_log_arb.sv
// Shares the sfdbs0 err_log/err_data/err_idx registers among NUM_SRC reporters: RR first-error capture, multi flag, drop count.
// Latency: src_vld in IDLE -> log write enables 1 cycle later -> log_code_q shows the write 2 cycles later.
// Backpressure: src_rdy is a registered one-cycle pulse; sources hold src_vld until it arrives.
// Ports: clk/rst; src_* per-reporter error payloads and vld/rdy; log_code_q/log_multi_q read back from the
//        register block; *_d/*_enb drive the register block write side; err_irq, proto_err pulses; drop_cnt.
module sfdbs0_err_log_arb
   import sfdbs0_err_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_SRC-1:0]   src_vld,
   output logic [NUM_SRC-1:0]   src_rdy,
   input  logic [NUM_SRC*3-1:0] src_code,
   input  logic [NUM_SRC-1:0]   src_access,
   input  logic [NUM_SRC*6-1:0] src_id,
   input  logic [NUM_SRC*32-1:0] src_data,
   input  logic [NUM_SRC*5-1:0] src_slice_idx,
   input  logic [NUM_SRC*4-1:0] src_group_idx,
   input  logic [2:0]           log_code_q,
   input  logic                 log_multi_q,
   output logic [2:0]           code_d,
   output logic                 access_d,
   output logic [5:0]           id_d,
   output logic                 multi_d,
   output logic                 code_enb,
   output logic                 access_enb,
   output logic                 id_enb,
   output logic                 multi_enb,
   output logic [31:0]          data_d,
   output logic                 data_enb,
   output logic [4:0]           slice_idx_d,
   output logic                 slice_idx_enb,
   output logic [3:0]           group_idx_d,
   output logic                 group_idx_enb,
   output logic                 err_irq,
   output logic                 proto_err,
   output logic [CNT_W-1:0]     drop_cnt
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   // ---------------------------------------------------------------- state
   arb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic                multi_sent_q, multi_sent_d;
   logic [CNT_W-1:0]    drop_q, drop_d;

   // Output flops (every output is registered).
   err_rec_t            rec_q, rec_d;
   logic                cap_q, cap_d;
   logic                multi_dat_q, multi_dat_d;
   logic                multi_enb_q, multi_enb_d;
   logic [NUM_SRC-1:0]  rdy_q, rdy_d;
   logic                irq_q, irq_d;
   logic                proto_q, proto_d;

   // ---------------------------------------------------------------- source unpack
   err_rec_t            rec [NUM_SRC];
   logic [NUM_SRC-1:0]  legal;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign rec[i] = '{code:      src_code[3*i +: 3],
                        access:    src_access[i],
                        id:        src_id[6*i +: 6],
                        data:      src_data[32*i +: 32],
                        slice_idx: src_slice_idx[5*i +: 5],
                        group_idx: src_group_idx[4*i +: 4]};
      assign legal[i] = (src_code[3*i +: 3] != ERR_CODE_NONE);
   end

   // rdy is registered, so a valid is still visible in the cycle its rdy pulse
   // is out; masking with rdy_q stops that same error from being taken twice.
   logic [NUM_SRC-1:0]  fresh;
   logic [NUM_SRC-1:0]  illegal_req;
   logic [NUM_SRC-1:0]  legal_req;

   assign fresh       = src_vld & ~rdy_q;
   assign illegal_req = fresh & ~legal;
   assign legal_req   = fresh & legal;

   logic [NUM_SRC-1:0]  gnt;
   logic [IDX_W-1:0]    gnt_idx;
   logic                gnt_any;

   sfdbs0_rr_arb #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_rr_arb (
      .req (legal_req),
      .ptr (rr_ptr_q),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   // Saturating drop counter: one extra bit catches the overflow.
   logic [CNT_W:0]      drop_sum;
   assign drop_sum = {1'b0, drop_q} + (CNT_W+1)'(popcount8(8'(legal_req)));

   // ---------------------------------------------------------------- next state / outputs
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      multi_sent_d = multi_sent_q;
      drop_d       = drop_q;
      rec_d        = '0;
      cap_d        = 1'b0;
      multi_dat_d  = 1'b0;
      multi_enb_d  = 1'b0;
      irq_d        = 1'b0;
      // Zero-code reports are swallowed in every state and never logged.
      rdy_d        = illegal_req;
      proto_d      = |illegal_req;

      case (state_q)
         IDLE: begin
            multi_sent_d = 1'b0;
            if (log_code_q != ERR_CODE_NONE) begin
               // Log still owned by software (e.g. stale across reset).
               state_d = HELD;
            end else if (gnt_any) begin
               state_d     = CAPTURE;
               rdy_d       = rdy_d | gnt;
               cap_d       = 1'b1;
               irq_d       = 1'b1;
               rec_d       = rec[gnt_idx];
               // Write multi=0 with the capture so a leftover multi is cleared.
               multi_enb_d = 1'b1;
               multi_dat_d = 1'b0;
               if (gnt_idx == IDX_W'(NUM_SRC-1)) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = gnt_idx + IDX_W'(1);
               end
            end
         end
         CAPTURE: begin
            state_d = SETTLE;
         end
         SETTLE: begin
            // Gives the register block a cycle so log_code_q shows the new code
            // before HELD starts testing it for the software clear.
            state_d = HELD;
         end
         HELD: begin
            if (log_code_q == ERR_CODE_NONE) begin
               // Software clear wins; pending errors are arbitrated from IDLE.
               state_d = IDLE;
            end else begin
               rdy_d = rdy_d | legal_req;
               if (drop_sum[CNT_W]) begin
                  drop_d = '1;
               end else begin
                  drop_d = drop_sum[CNT_W-1:0];
               end
               if ((|legal_req) && !log_multi_q && !multi_sent_q) begin
                  multi_enb_d  = 1'b1;
                  multi_dat_d  = 1'b1;
                  multi_sent_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         multi_sent_q <= 1'b0;
         drop_q       <= '0;
         rec_q        <= '0;
         cap_q        <= 1'b0;
         multi_dat_q  <= 1'b0;
         multi_enb_q  <= 1'b0;
         rdy_q        <= '0;
         irq_q        <= 1'b0;
         proto_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         multi_sent_q <= multi_sent_d;
         drop_q       <= drop_d;
         rec_q        <= rec_d;
         cap_q        <= cap_d;
         multi_dat_q  <= multi_dat_d;
         multi_enb_q  <= multi_enb_d;
         rdy_q        <= rdy_d;
         irq_q        <= irq_d;
         proto_q      <= proto_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign src_rdy       = rdy_q;
   assign code_d        = rec_q.code;
   assign access_d      = rec_q.access;
   assign id_d          = rec_q.id;
   assign data_d        = rec_q.data;
   assign slice_idx_d   = rec_q.slice_idx;
   assign group_idx_d   = rec_q.group_idx;
   assign code_enb      = cap_q;
   assign access_enb    = cap_q;
   assign id_enb        = cap_q;
   assign data_enb      = cap_q;
   assign slice_idx_enb = cap_q;
   assign group_idx_enb = cap_q;
   assign multi_d       = multi_dat_q;
   assign multi_enb     = multi_enb_q;
   assign err_irq       = irq_q;
   assign proto_err     = proto_q;
   assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_sfdbs0_err_log_arb.sv
// Bench for sfdbs0_err_log_arb: vector table for the main flow plus hand sequences for saturation and reset.
// Latency: outputs compared 1 ns after each rising edge.
// Backpressure: sources hold src_vld until a src_rdy pulse is seen, then drop it.
module tb_sfdbs0_err_log_arb;

   localparam int N  = 4;
   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    src_vld;
   logic [N-1:0]    src_rdy;
   logic [N*3-1:0]  src_code;
   logic [N-1:0]    src_access;
   logic [N*6-1:0]  src_id;
   logic [N*32-1:0] src_data;
   logic [N*5-1:0]  src_slice_idx;
   logic [N*4-1:0]  src_group_idx;
   logic [2:0]      log_code_q;
   logic            log_multi_q;
   logic [2:0]      code_d;
   logic            access_d;
   logic [5:0]      id_d;
   logic            multi_d;
   logic            code_enb, access_enb, id_enb, multi_enb;
   logic [31:0]     data_d;
   logic            data_enb;
   logic [4:0]      slice_idx_d;
   logic            slice_idx_enb;
   logic [3:0]      group_idx_d;
   logic            group_idx_enb;
   logic            err_irq;
   logic            proto_err;
   logic [CW-1:0]   drop_cnt;

   always #5 clk = ~clk;

   sfdbs0_err_log_arb #(.NUM_SRC(N), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .src_vld       (src_vld),
      .src_rdy       (src_rdy),
      .src_code      (src_code),
      .src_access    (src_access),
      .src_id        (src_id),
      .src_data      (src_data),
      .src_slice_idx (src_slice_idx),
      .src_group_idx (src_group_idx),
      .log_code_q    (log_code_q),
      .log_multi_q   (log_multi_q),
      .code_d        (code_d),
      .access_d      (access_d),
      .id_d          (id_d),
      .multi_d       (multi_d),
      .code_enb      (code_enb),
      .access_enb    (access_enb),
      .id_enb        (id_enb),
      .multi_enb     (multi_enb),
      .data_d        (data_d),
      .data_enb      (data_enb),
      .slice_idx_d   (slice_idx_d),
      .slice_idx_enb (slice_idx_enb),
      .group_idx_d   (group_idx_d),
      .group_idx_enb (group_idx_enb),
      .err_irq       (err_irq),
      .proto_err     (proto_err),
      .drop_cnt      (drop_cnt)
   );

   // Fixed per-source payloads; source 1 is the 0x2A / 0xDEADBEEF reporter.
   logic [2:0]  p_code  [N] = '{3'd1, 3'd3, 3'd5, 3'd7};
   logic        p_acc   [N] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic [5:0]  p_id    [N] = '{6'h11, 6'h2A, 6'h33, 6'h3C};
   logic [31:0] p_data  [N] = '{32'h0000_1000, 32'hDEAD_BEEF, 32'hCAFE_0002, 32'h1234_5673};
   logic [4:0]  p_slice [N] = '{5'd1, 5'd2, 5'd3, 5'd4};
   logic [3:0]  p_group [N] = '{4'd5, 4'd6, 4'd7, 4'd8};

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, tag, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic set_codes(input logic [N-1:0] zmask);
      for (int i = 0; i < N; i++) begin
         src_code[3*i +: 3]       = zmask[i] ? 3'd0 : p_code[i];
         src_access[i]            = p_acc[i];
         src_id[6*i +: 6]         = p_id[i];
         src_data[32*i +: 32]     = p_data[i];
         src_slice_idx[5*i +: 5]  = p_slice[i];
         src_group_idx[4*i +: 4]  = p_group[i];
      end
   endtask

   // One clock: models the register block write-back and the source handshake.
   task automatic tick();
      logic         ce;
      logic [2:0]   cd;
      logic         me;
      logic         md;
      logic [N-1:0] hs;
      ce = code_enb;
      cd = code_d;
      me = multi_enb;
      md = multi_d;
      hs = src_vld & src_rdy;
      @(posedge clk);
      #1;
      if (ce) log_code_q = cd;
      if (me) log_multi_q = md;
      src_vld = src_vld & ~hs;
   endtask

   typedef struct {
      logic          clr;
      logic [N-1:0]  add_vld;
      logic [N-1:0]  zmask;
      logic [N-1:0]  exp_rdy;
      logic          exp_cap;
      int            exp_src;
      logic          exp_irq;
      logic          exp_proto;
      logic          exp_menb;
      logic          exp_mdat;
      logic [CW-1:0] exp_drop;
   } vec_t;

   function automatic vec_t mk(logic clr, logic [N-1:0] add, logic [N-1:0] zm, logic [N-1:0] rdy,
                               logic cap, int src, logic irq, logic proto, logic menb, logic mdat,
                               logic [CW-1:0] drop);
      vec_t v;
      v.clr = clr; v.add_vld = add; v.zmask = zm; v.exp_rdy = rdy; v.exp_cap = cap;
      v.exp_src = src; v.exp_irq = irq; v.exp_proto = proto; v.exp_menb = menb;
      v.exp_mdat = mdat; v.exp_drop = drop;
      return v;
   endfunction

   localparam int NV = 28;
   vec_t vt [NV];

   initial begin
      int pulses;

      //            clr  add      zmask    rdy      cap src irq pro menb mdat drop
      vt[0]  = mk(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0); // src1 captured
      vt[1]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      vt[2]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      vt[3]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      vt[4]  = mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0); // sw clear
      vt[5]  = mk(1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0); // ptr=2 -> src2
      vt[6]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      vt[7]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      vt[8]  = mk(1'b0, 4'b0000, 4'b0000, 4'b1011, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3); // dropped in HELD
      vt[9]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
      vt[10] = mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
      vt[11] = mk(1'b0, 4'b1001, 4'b0000, 4'b1000, 1'b1, 3, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3); // ptr=3 -> src3
      vt[12] = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
      vt[13] = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
      vt[14] = mk(1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4);
      vt[15] = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
      vt[16] = mk(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4); // clear + vld
      vt[17] = mk(1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4);
      vt[18] = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
      vt[19] = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
      vt[20] = mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
      vt[21] = mk(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4); // code 0
      vt[22] = mk(1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
      vt[23] = mk(1'b0, 4'b0101, 4'b0000, 4'b0100, 1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4); // ptr still 1
      vt[24] = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
      vt[25] = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
      vt[26] = mk(1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
      vt[27] = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);

      // ------------------------------------------------ reset state
      rst         = 1'b1;
      src_vld     = '0;
      log_code_q  = 3'd0;
      log_multi_q = 1'b0;
      set_codes('0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rdy", -1, 32'(src_rdy), 32'd0);
      chk("reset_enb", -1, 32'({code_enb, access_enb, id_enb, multi_enb, data_enb, slice_idx_enb, group_idx_enb}), 32'd0);
      chk("reset_pulses", -1, 32'({err_irq, proto_err}), 32'd0);
      chk("reset_drop", -1, 32'(drop_cnt), 32'd0);
      chk("reset_data", -1, data_d, 32'd0);
      rst = 1'b0;

      // ------------------------------------------------ vector table
      for (int r = 0; r < NV; r++) begin
         if (vt[r].clr) log_code_q = 3'd0;
         src_vld = src_vld | vt[r].add_vld;
         set_codes(vt[r].zmask);
         tick();
         chk("src_rdy", r, 32'(src_rdy), 32'(vt[r].exp_rdy));
         chk("log_enb", r, 32'({code_enb, access_enb, id_enb, data_enb, slice_idx_enb, group_idx_enb}),
             32'({6{vt[r].exp_cap}}));
         chk("err_irq", r, 32'(err_irq), 32'(vt[r].exp_irq));
         chk("proto_err", r, 32'(proto_err), 32'(vt[r].exp_proto));
         chk("multi_enb", r, 32'(multi_enb), 32'(vt[r].exp_menb));
         chk("multi_d", r, 32'(multi_d), 32'(vt[r].exp_mdat));
         chk("drop_cnt", r, 32'(drop_cnt), 32'(vt[r].exp_drop));
         if (vt[r].exp_cap) begin
            chk("code_d", r, 32'(code_d), 32'(p_code[vt[r].exp_src]));
            chk("access_d", r, 32'(access_d), 32'(p_acc[vt[r].exp_src]));
            chk("id_d", r, 32'(id_d), 32'(p_id[vt[r].exp_src]));
            chk("data_d", r, data_d, p_data[vt[r].exp_src]);
            chk("slice_idx_d", r, 32'(slice_idx_d), 32'(p_slice[vt[r].exp_src]));
            chk("group_idx_d", r, 32'(group_idx_d), 32'(p_group[vt[r].exp_src]));
         end
      end

      // ------------------------------------------------ saturation: 20 drops in one HELD episode
      log_code_q = 3'd0;
      tick();                      // HELD -> IDLE
      src_vld = src_vld | 4'b0100;
      tick();                      // CAPTURE outputs
      chk("sat_capture", 100, 32'(code_enb), 32'd1);
      tick();                      // SETTLE
      tick();                      // HELD
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         src_vld = src_vld | 4'b0011;
         tick();
         if (multi_enb && multi_d) pulses++;
         tick();
         if (multi_enb && multi_d) pulses++;
      end
      chk("sat_drop_cnt", 101, 32'(drop_cnt), 32'hF);
      chk("sat_multi_pulses", 102, 32'(pulses), 32'd1);

      // ------------------------------------------------ reset during CAPTURE
      log_code_q = 3'd0;
      tick();                      // HELD -> IDLE
      src_vld = src_vld | 4'b0001;
      tick();                      // CAPTURE outputs for src0
      chk("rst_pre_enb", 200, 32'(code_enb), 32'd1);
      chk("rst_pre_rdy", 200, 32'(src_rdy), 32'b0001);
      #2;
      rst         = 1'b1;
      log_code_q  = 3'd6;          // stale log left for software
      log_multi_q = 1'b0;
      #1;
      chk("rst_async_enb", 201, 32'({code_enb, access_enb, id_enb, multi_enb, data_enb, slice_idx_enb, group_idx_enb}), 32'd0);
      chk("rst_async_rdy", 201, 32'(src_rdy), 32'd0);
      chk("rst_async_irq", 201, 32'(err_irq), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();                      // IDLE sees stale code -> HELD
      chk("rst_idle_rdy", 202, 32'(src_rdy), 32'd0);
      chk("rst_idle_enb", 202, 32'(code_enb), 32'd0);
      tick();                      // HELD drops the pending src0
      chk("rst_held_rdy", 203, 32'(src_rdy), 32'b0001);
      chk("rst_held_enb", 203, 32'(code_enb), 32'd0);
      chk("rst_held_multi", 203, 32'({multi_enb, multi_d}), 32'b11);
      chk("rst_held_drop", 203, 32'(drop_cnt), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
